mul_trunc_pipe: RTL and testbench

Pipelined, parametrised unsigned approximate multiplier that zeroes a runtime-selectable number of operand LSBs before multiplying. It is the next generation of the fixed 12x12, fixed 5-bit truncated multipliers in the approximate-arithmetic library. It adds a valid/ready stream interface, a configurable pipeline depth and per-transaction accuracy selection. It sits between operand producers and accumulators in approximate datapaths where accuracy is traded for power at run time.

---
 rtl/mul_trunc_pipe.sv | 106 ++++++++++
 tb/tb_mul_trunc_pipe.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/mul_trunc_pipe.sv
// rtl/mul_trunc_pipe.sv - pipelined unsigned multiplier that zeroes a runtime-selected number of operand LSBs
// Optional bias compensation when APXMUL_BIAS_COMP_EN is defined.
module mul_trunc_pipe #(
  parameter int WIDTH     = 12,
  parameter int MAX_TRUNC = 8,
  parameter int STAGES    = 2,
  localparam int TW       = (MAX_TRUNC > 0) ? $clog2(MAX_TRUNC + 1) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic [TW-1:0]      trunc,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] z,
  output logic [TW-1:0]      z_trunc
);

  localparam int ZW = 2 * WIDTH;
  localparam logic [TW-1:0] T_MAX = TW'(MAX_TRUNC);

  logic [TW-1:0]     tSat;
  logic [WIDTH-1:0]  keepMask;
  logic [WIDTH-1:0]  aMasked;
  logic [WIDTH-1:0]  bMasked;
  logic [STAGES-1:0] slotReady;
  logic [STAGES-1:0] slotValid;
  logic [ZW-1:0]     slotData  [STAGES];
  logic [TW-1:0]     slotTrunc [STAGES];
  logic [WIDTH-1:0]  opA;
  logic [WIDTH-1:0]  opB;
  logic [ZW-1:0]     product;

  always_comb begin
    tSat     = (trunc > T_MAX) ? T_MAX : trunc;
    keepMask = {WIDTH{1'b1}} << tSat;
    aMasked  = a & keepMask;
    bMasked  = b & keepMask;
  end

  // A slot can take data when it or any slot after it is empty, or the consumer drains.
  always_comb begin
    for (int i = 0; i < STAGES; i++) begin
      slotReady[i] = out_ready;
      for (int j = i; j < STAGES; j++) begin
        if (!slotValid[j]) slotReady[i] = 1'b1;
      end
    end
  end

  assign in_ready = slotReady[0];

  // Slot 0 holds the masked operands; the multiply sits between slot 0 and the next register.
  assign opA = slotData[0][ZW-1:WIDTH];
  assign opB = slotData[0][WIDTH-1:0];

  always_comb begin
    product = ZW'(opA) * ZW'(opB);
`ifdef APXMUL_BIAS_COMP_EN
    if (slotTrunc[0] != '0 && opA != '0 && opB != '0)
      product = product + (((ZW'(1) << slotTrunc[0]) - ZW'(1)) << (WIDTH - 1));
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        slotValid[i] <= 1'b0;
        slotData[i]  <= '0;
        slotTrunc[i] <= '0;
      end
    end else begin
      if (slotReady[0]) begin
        slotValid[0] <= in_valid;
        if (in_valid) begin
          slotData[0]  <= {aMasked, bMasked};
          slotTrunc[0] <= tSat;
        end
      end
      for (int i = 1; i < STAGES; i++) begin
        if (slotReady[i]) begin
          slotValid[i] <= slotValid[i-1];
          if (slotValid[i-1]) begin
            slotData[i]  <= (i == 1) ? product : slotData[i-1];
            slotTrunc[i] <= slotTrunc[i-1];
          end
        end
      end
    end
  end

  generate
    if (STAGES == 1) begin : g_single
      assign z = product;
    end else begin : g_multi
      assign z = slotData[STAGES-1];
    end
  endgenerate

  assign out_valid = slotValid[STAGES-1];
  assign z_trunc   = slotTrunc[STAGES-1];

endmodule

// File: tb/tb_mul_trunc_pipe.sv
// tb/tb_mul_trunc_pipe.sv - self-checking bench for mul_trunc_pipe (WIDTH=12, MAX_TRUNC=8, STAGES=2)
module tb_mul_trunc_pipe;

  localparam int W    = 12;
  localparam int MAXT = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  a = '0;
  logic [W-1:0]  b = '0;
  logic [3:0]    trunc = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [2*W-1:0] z;
  logic [3:0]    z_trunc;

  int checks = 0;
  int failures = 0;
  int acceptCount = 0;
  int outCount = 0;

  typedef struct packed {
    logic [2*W-1:0] z;
    logic [3:0]     t;
  } exp_t;

  typedef struct {
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic [3:0]     tr;
    logic [2*W-1:0] z;
    logic [3:0]     t;
  } vec_t;

  exp_t           expQ[$];
  logic           holding = 1'b0;
  logic [2*W-1:0] heldZ;
  logic [3:0]     heldT;

  mul_trunc_pipe #(.WIDTH(W), .MAX_TRUNC(MAXT), .STAGES(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .trunc(trunc), .out_valid(out_valid), .out_ready(out_ready),
    .z(z), .z_trunc(z_trunc)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, req);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] aa, input logic [W-1:0] bb, input logic [3:0] tr);
    int     t;
    longint am, bm, zz;
    exp_t   r;
    t  = (int'(tr) > MAXT) ? MAXT : int'(tr);
    am = longint'(aa);
    bm = longint'(bb);
    am = (am >> t) << t;
    bm = (bm >> t) << t;
    zz = am * bm;
`ifdef APXMUL_BIAS_COMP_EN
    if (t > 0 && am != 0 && bm != 0) zz = zz + (((longint'(1) << t) - 1) << (W - 1));
`endif
    r.z = zz[2*W-1:0];
    r.t = 4'(t);
    return r;
  endfunction

  // Scoreboard: handshakes seen at the falling edge complete on the next rising edge.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      expQ.delete();
      holding = 1'b0;
    end else begin
      if (holding) begin
        check("hold_z", z, heldZ);
        check("hold_t", z_trunc, heldT);
      end
      if (out_valid && out_ready) begin
        check("sb_nonempty", expQ.size() > 0, 1);
        if (expQ.size() > 0) begin
          e = expQ.pop_front();
          check("sb_z", z, e.z);
          check("sb_t", z_trunc, e.t);
        end
        outCount++;
      end
      if (in_valid && in_ready) begin
        expQ.push_back(model(a, b, trunc));
        acceptCount++;
      end
      holding = out_valid && !out_ready;
      heldZ   = z;
      heldT   = z_trunc;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    int   base;
    logic [2*W-1:0] zHold;

    vecs[0] = '{12'h123, 12'h456, 4'd0,  24'h04EDC2, 4'd0};
    vecs[3] = '{12'hFFF, 12'hFFF, 4'd0,  24'hFFE001, 4'd0};
    vecs[4] = '{12'h0FF, 12'hFFF, 4'd8,  24'h000000, 4'd8};
    vecs[6] = '{12'h000, 12'hABC, 4'd3,  24'h000000, 4'd3};
`ifdef APXMUL_BIAS_COMP_EN
    vecs[1] = '{12'hFFF, 12'hFFF, 4'd5,  24'hFCFC00, 4'd5};
    vecs[2] = '{12'h1FF, 12'h3FF, 4'd15, 24'h0AF800, 4'd8};
    vecs[5] = '{12'hFFF, 12'hFFF, 4'd8,  24'hE8F800, 4'd8};
    vecs[7] = '{12'h800, 12'h801, 4'd1,  24'h400800, 4'd1};
`else
    vecs[1] = '{12'hFFF, 12'hFFF, 4'd5,  24'hFC0400, 4'd5};
    vecs[2] = '{12'h1FF, 12'h3FF, 4'd15, 24'h030000, 4'd8};
    vecs[5] = '{12'hFFF, 12'hFFF, 4'd8,  24'hE10000, 4'd8};
    vecs[7] = '{12'h800, 12'h801, 4'd1,  24'h400000, 4'd1};
`endif

    #2;
    check("rst_out_valid", out_valid, 0);
    check("rst_z", z, 0);
    check("rst_z_trunc", z_trunc, 0);
    check("rst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b1; a = vecs[i].a; b = vecs[i].b; trunc = vecs[i].tr; out_ready = 1'b1;
      @(negedge clk);
      check("vec_in_ready", in_ready, 1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(negedge clk);
      check("vec_lat_early", out_valid, 0);
      @(negedge clk);
      check("vec_out_valid", out_valid, 1);
      check("vec_z", z, vecs[i].z);
      check("vec_z_trunc", z_trunc, vecs[i].t);
    end
    @(posedge clk); #1;

    base = outCount;
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; a = 12'($urandom); b = 12'($urandom); trunc = 4'($urandom_range(0, 15));
      @(negedge clk);
      check("stream_in_ready", in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    check("stream_count", outCount - base, 10);
    @(negedge clk);
    check("stream_idle", out_valid, 0);

    @(posedge clk); #1;
    out_ready = 1'b0;
    base = acceptCount;
    for (int k = 0; k < 5; k++) begin
      in_valid = 1'b1; a = 12'($urandom); b = 12'($urandom); trunc = 4'($urandom_range(0, 15));
      @(posedge clk); #1;
    end
    check("stall_accepted", acceptCount - base, 2);
    check("stall_in_ready", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    zHold = z;
    repeat (3) @(posedge clk);
    #1;
    check("stall_z_stable", z, zHold);
    check("stall_still_full", acceptCount - base, 2);
    in_valid = 1'b0; out_ready = 1'b1;
    base = outCount;
    for (int k = 0; k < 20 && outCount - base < 2; k++) @(negedge clk);
    #2;
    check("stall_drain_count", outCount - base, 2);
    check("stall_drain_empty", expQ.size(), 0);

    for (int k = 0; k < 300; k++) begin
      @(posedge clk); #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      a = 12'($urandom); b = 12'($urandom); trunc = 4'($urandom_range(0, 15));
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    for (int k = 0; k < 40 && expQ.size() != 0; k++) @(negedge clk);
    #2;
    check("rand_drain_empty", expQ.size(), 0);

    @(posedge clk); #1;
    in_valid = 1'b1; a = 12'h3C5; b = 12'h7A1; trunc = 4'd2;
    @(posedge clk); #1;
    a = 12'h111; b = 12'h222; trunc = 4'd0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("pre_rst_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_z", z, 0);
    check("midrst_z_trunc", z_trunc, 0);
    check("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("after_rst_no_output", out_valid, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
